// File: rtl/regfl_pkg.sv
// Shared definitions for the register-file reduction block.
//   - default register count and width
//   - index and sum-extension widths
//   - FSM state encoding
package regfl_pkg;

  // Defaults for the consumed register-file image.
  localparam int unsigned NREG_DEF = 8;
  localparam int unsigned W_DEF    = 64;

  // Largest register count the 3-bit index and 3 guard bits can cover.
  localparam int unsigned MAX_NREG = 8;

  // Index width; max_idx is fixed at 3 bits.
  localparam int unsigned IDX_W = 3;

  // Three guard bits hold the sum of up to eight full-scale words.
  localparam int unsigned SUM_EXT = 3;
  localparam int unsigned SUM_W   = W_DEF + SUM_EXT;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/regfl_sum_dp.sv
// Datapath for regfl_sum.
// Holds a snapshot of the register-file image, selects one word per step by
// index, accumulates the sum and tracks the maximum and its index.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : capture q_in into the snapshot and clear sum/max/max_idx
//   step     : fold snapshot word idx into sum and max
//   idx      : word index for the current step
//   q_in     : register-file image, register 0 in the MSB slice
//   sum      : running / final unsigned sum (W+3 bits)
//   max      : running / final maximum
//   max_idx  : index of max, lowest index wins ties
module regfl_sum_dp
  import regfl_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic [IDX_W-1:0]        idx,
  input  logic [NREG*W-1:0]       q_in,
  output logic [W+SUM_EXT-1:0]    sum,
  output logic [W-1:0]            max,
  output logic [IDX_W-1:0]        max_idx
);

  localparam int unsigned SumW = W + SUM_EXT;

  logic [NREG-1:0][W-1:0] snap_q;
  logic [W-1:0]           word;
  logic [SumW-1:0]        sum_q, sum_d;
  logic [W-1:0]           max_q, max_d;
  logic [IDX_W-1:0]       max_idx_q, max_idx_d;

  // Snapshot element i is register i, taken from the MSB end of q_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (load) begin
      for (int i = 0; i < NREG; i++) begin
        snap_q[i] <= q_in[(NREG-1-i)*W +: W];
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == IDX_W'(i)) begin
        word = snap_q[i];
      end
    end
  end

  always_comb begin
    sum_d     = sum_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    if (load) begin
      sum_d     = '0;
      max_d     = '0;
      max_idx_d = '0;
    end else if (step) begin
      sum_d = sum_q + SumW'(word);
      // Strict compare keeps the earliest index on ties; word 0 always seeds.
      if (idx == '0 || word > max_q) begin
        max_d     = word;
        max_idx_d = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
    end else begin
      sum_q     <= sum_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign sum     = sum_q;
  assign max     = max_q;
  assign max_idx = max_idx_q;

endmodule

// File: rtl/regfl_sum.sv
// Register-file reduction: on start, snapshots an NREG x W register image and
// walks it one word per cycle, producing the unsigned sum and the maximum with
// its index. The result is held under a valid/ready handshake.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : begin a pass (honoured only when idle)
//   q_in     : register-file image, register 0 in the MSB slice
//   busy     : pass in progress or result pending
//   valid    : result available
//   ready    : downstream accepts the result
//   sum      : unsigned sum, W+3 bits
//   max      : largest register value
//   max_idx  : index of max
module regfl_sum
  import regfl_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NREG*W-1:0]    q_in,
  output logic                 busy,
  output logic                 valid,
  input  logic                 ready,
  output logic [W+SUM_EXT-1:0] sum,
  output logic [W-1:0]         max,
  output logic [IDX_W-1:0]     max_idx
);

  if (NREG > MAX_NREG || NREG < 1) begin : gen_cfg_err
    $error("regfl_sum: NREG must be in 1..8");
  end

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NREG - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load, step;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        // start is deliberately ignored here, even on the handshake edge.
        if (ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = (state_q == StDone);

  regfl_sum_dp #(
    .NREG (NREG),
    .W    (W)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .idx     (idx_q),
    .q_in    (q_in),
    .sum     (sum),
    .max     (max),
    .max_idx (max_idx)
  );

endmodule

// File: tb/tb_regfl_sum.sv
module tb_regfl_sum;

  localparam int NREG = 8;
  localparam int W    = 64;
  // Edges after the capture edge until valid is seen (9 edges including it).
  localparam int LAT  = NREG;

  typedef logic [W-1:0] img_t [NREG];

  logic              clk = 1'b0;
  logic              rst, start, ready;
  logic [NREG*W-1:0] q_in;
  logic              busy, valid;
  logic [W+2:0]      sum;
  logic [W-1:0]      max;
  logic [2:0]        max_idx;

  int n_tests = 0;
  int n_fail  = 0;

  regfl_sum #(
    .NREG (NREG),
    .W    (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .q_in    (q_in),
    .busy    (busy),
    .valid   (valid),
    .ready   (ready),
    .sum     (sum),
    .max     (max),
    .max_idx (max_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREG*W-1:0] pack(input img_t img);
    logic [NREG*W-1:0] p;
    p = '0;
    for (int i = 0; i < NREG; i++) p[(NREG-1-i)*W +: W] = img[i];
    return p;
  endfunction

  // Reference: plain arithmetic sum; maximum value first, then its first index.
  task automatic model(input img_t img, output logic [W+2:0] s, output logic [W-1:0] m,
                       output logic [2:0] mi);
    s = '0;
    m = '0;
    mi = '0;
    for (int i = 0; i < NREG; i++) begin
      s = s + {3'b000, img[i]};
      if (img[i] > m) m = img[i];
    end
    for (int i = NREG - 1; i >= 0; i--) if (img[i] == m) mi = 3'(i);
  endtask

  task automatic rand_img(output img_t img);
    for (int i = 0; i < NREG; i++) img[i] = {$urandom, $urandom};
  endtask

  task automatic start_pass(input img_t img);
    q_in  = pack(img);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges until valid; 0 if the bound expires.
  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0; q_in = '0;
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %0h want 0", sum); end
    n_tests++; if (max !== '0) begin n_fail++; $display("FAIL reset_max: got %0h want 0", max); end
    n_tests++; if (max_idx !== 3'd0) begin n_fail++; $display("FAIL reset_max_idx: got %0d want 0", max_idx); end
  endtask

  task automatic test_basic();
    img_t img;
    logic [W+2:0] es; logic [W-1:0] em; logic [2:0] ei;
    int n;
    for (int i = 0; i < NREG; i++) img[i] = W'(i + 1);
    model(img, es, em, ei);
    ready = 1'b1;
    start_pass(img);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_valid(n);
    n_tests++; if (n != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", n, LAT); end
    n_tests++; if (sum !== 67'd36 || es != 67'd36) begin n_fail++; $display("FAIL basic_sum: got %0d want 36", sum); end
    n_tests++; if (max !== 64'd8) begin n_fail++; $display("FAIL basic_max: got %0d want 8", max); end
    n_tests++; if (max_idx !== 3'd7) begin n_fail++; $display("FAIL basic_max_idx: got %0d want 7", max_idx); end
    tick();
    n_tests++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got valid=%b busy=%b want 0 0", valid, busy); end
    n_tests++; if (sum !== es || max !== em || max_idx !== ei) begin n_fail++;
      $display("FAIL basic_hold: got %0h/%0h/%0d want %0h/%0h/%0d", sum, max, max_idx, es, em, ei); end
  endtask

  task automatic test_overflow_tie();
    img_t img;
    logic [W+2:0] es; logic [W-1:0] em; logic [2:0] ei;
    int n;
    for (int i = 0; i < NREG; i++) img[i] = '1;
    model(img, es, em, ei);
    ready = 1'b1;
    start_pass(img);
    wait_valid(n);
    n_tests++; if (n != LAT) begin n_fail++; $display("FAIL ovf_latency: got %0d want %0d", n, LAT); end
    n_tests++; if (sum !== 67'h7_FFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL ovf_sum: got %0h want 7fffffffffffffff8", sum); end
    n_tests++; if (sum !== es) begin n_fail++; $display("FAIL ovf_sum_model: got %0h want %0h", sum, es); end
    n_tests++; if (max !== '1) begin n_fail++; $display("FAIL ovf_max: got %0h want all ones", max); end
    n_tests++; if (max_idx !== 3'd0) begin n_fail++; $display("FAIL ovf_max_idx: got %0d want 0", max_idx); end
    tick();
  endtask

  task automatic test_backpressure();
    img_t a, b;
    logic [W+2:0] es; logic [W-1:0] em; logic [2:0] ei;
    int n;
    rand_img(a);
    rand_img(b);
    model(a, es, em, ei);
    ready = 1'b0;
    start_pass(a);
    // Image changes and start is held for the whole pass.
    q_in  = pack(b);
    start = 1'b1;
    wait_valid(n);
    n_tests++; if (n != LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", n, LAT); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (valid !== 1'b1 || sum !== es || max !== em || max_idx !== ei) begin n_fail++;
        $display("FAIL bp_stable[%0d]: got v=%b %0h/%0h/%0d want v=1 %0h/%0h/%0d", k, valid, sum, max, max_idx, es, em, ei); end
      tick();
    end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL bp_still_valid: got %b want 1", valid); end
    ready = 1'b1;
    tick();
    n_tests++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got valid=%b busy=%b want 0 0", valid, busy); end
    start = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_new_pass: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    img_t a, t;
    logic [W+2:0] es; logic [W-1:0] em; logic [2:0] ei;
    int n;
    rand_img(a);
    ready = 1'b1;
    start_pass(a);
    tick(); tick(); tick(); tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0 || valid !== 1'b0 || sum !== '0 || max !== '0 || max_idx !== 3'd0) begin n_fail++;
      $display("FAIL rmid_cleared: got b=%b v=%b %0h/%0h/%0d want 0 0 0/0/0", busy, valid, sum, max, max_idx); end
    for (int i = 0; i < NREG; i++) t[i] = '0;
    t[0] = 64'd10;
    model(t, es, em, ei);
    start_pass(t);
    wait_valid(n);
    n_tests++; if (n != LAT) begin n_fail++; $display("FAIL rmid_latency: got %0d want %0d", n, LAT); end
    n_tests++; if (sum !== 67'd10 || max !== 64'd10 || max_idx !== 3'd0) begin n_fail++;
      $display("FAIL rmid_result: got %0h/%0h/%0d want a/a/0", sum, max, max_idx); end
    tick();
  endtask

  task automatic test_back_to_back();
    img_t a, b;
    logic [W+2:0] es; logic [W-1:0] em; logic [2:0] ei;
    int n;
    rand_img(a);
    rand_img(b);
    ready = 1'b1;
    model(a, es, em, ei);
    start_pass(a);
    wait_valid(n);
    n_tests++; if (sum !== es || max !== em || max_idx !== ei) begin n_fail++;
      $display("FAIL b2b_first: got %0h/%0h/%0d want %0h/%0h/%0d", sum, max, max_idx, es, em, ei); end
    tick();
    model(b, es, em, ei);
    start_pass(b);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_valid(n);
    n_tests++; if (n != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", n, LAT); end
    n_tests++; if (sum !== es || max !== em || max_idx !== ei) begin n_fail++;
      $display("FAIL b2b_second: got %0h/%0h/%0d want %0h/%0h/%0d", sum, max, max_idx, es, em, ei); end
    tick();
  endtask

  task automatic test_random();
    img_t a;
    logic [W+2:0] es; logic [W-1:0] em; logic [2:0] ei;
    int n, hold;
    for (int it = 0; it < 10; it++) begin
      rand_img(a);
      if (it % 3 == 1) for (int i = 0; i < NREG; i++) a[i] = W'($urandom_range(0, 5));
      if (it % 2 == 0) a[$urandom_range(4, 7)] = a[$urandom_range(0, 3)];
      model(a, es, em, ei);
      ready = 1'b0;
      start_pass(a);
      wait_valid(n);
      n_tests++; if (n != LAT) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, n, LAT); end
      n_tests++; if (sum !== es || max !== em || max_idx !== ei) begin n_fail++;
        $display("FAIL rand_result[%0d]: got %0h/%0h/%0d want %0h/%0h/%0d", it, sum, max, max_idx, es, em, ei); end
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) tick();
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rand_hold[%0d]: got %b want 1", it, valid); end
      ready = 1'b1;
      tick();
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rand_release[%0d]: got %b want 0", it, valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_tie();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
